// File: rtl/scb_issue_ctrl_pip0_pkg.sv
// scb_pkg: shared widths, the table entry type and the allocation priority
// encoder for the pipe-0 issue controller.
//   N_CELL          number of table entries
//   W_ident         entry index width
//   W_pip           pipe tag width
//   W_PA_rx         destination register address width
//   W_state         latency countdown width
//   V_FUT0/V_FUT1   countdown values exported as structural hazard flags
package scb_pkg;

    localparam int N_CELL  = 8;
    localparam int W_ident = 4;
    localparam int W_pip   = 2;
    localparam int W_PA_rx = 5;
    localparam int W_state = 7;
    localparam int V_FUT0  = 1;
    localparam int V_FUT1  = 4;
    localparam int W_cnt   = $clog2(N_CELL + 1);

    typedef struct packed {
        logic               inused;
        logic [W_pip-1:0]   pip;
        logic [W_PA_rx-1:0] rd;
        logic [W_state-1:0] state;
    } scb_entry_t;

    // Lowest-index set bit; returns 0 when nothing is free (caller gates on that).
    function automatic logic [W_ident-1:0] find_first_free(input logic [N_CELL-1:0] free_vec);
        logic [W_ident-1:0] idx;
        idx = '0;
        for (int i = N_CELL - 1; i >= 0; i--) begin
            if (free_vec[i]) idx = W_ident'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/scb_issue_ctrl_pip0_slot.sv
// scb_slot: one scoreboard table entry.
//   clk, rst        clock, synchronous active-high reset
//   clear_i         flush: entry drops at the next edge
//   load_i          allocate this entry with pip_i/rd_i/state_i
//   match_val_i     req_state+1, one bit wider than the countdown
//   inused_o, pip_o, rd_o   registered entry fields
//   is_wb_o         entry completes this cycle
//   is_fut0_o/is_fut1_o     countdown equals V_FUT0/V_FUT1
//   match_o         countdown equals match_val_i (issue collision)
module scb_slot
    import scb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_i,
    input  logic               load_i,
    input  logic [W_pip-1:0]   pip_i,
    input  logic [W_PA_rx-1:0] rd_i,
    input  logic [W_state-1:0] state_i,
    input  logic [W_state:0]   match_val_i,
    output logic               inused_o,
    output logic [W_pip-1:0]   pip_o,
    output logic [W_PA_rx-1:0] rd_o,
    output logic               is_wb_o,
    output logic               is_fut0_o,
    output logic               is_fut1_o,
    output logic               match_o
);

    scb_entry_t entry_q, entry_d;

    // Load is only ever asserted on a free entry, so it never races the
    // countdown/retire path of a live entry.
    always_comb begin
        entry_d = entry_q;
        if (clear_i) begin
            entry_d.inused = 1'b0;
        end else if (load_i) begin
            entry_d.inused = 1'b1;
            entry_d.pip    = pip_i;
            entry_d.rd     = rd_i;
            entry_d.state  = state_i;
        end else if (entry_q.inused) begin
            if (entry_q.state == '0) entry_d.inused = 1'b0;
            else                     entry_d.state  = entry_q.state - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) entry_q <= '0;
        else     entry_q <= entry_d;
    end

    assign inused_o  = entry_q.inused;
    assign pip_o     = entry_q.pip;
    assign rd_o      = entry_q.rd;
    assign is_wb_o   = entry_q.inused && (entry_q.state == '0);
    assign is_fut0_o = entry_q.inused && (entry_q.state == W_state'(V_FUT0));
    assign is_fut1_o = entry_q.inused && (entry_q.state == W_state'(V_FUT1));
    assign match_o   = entry_q.inused && ({1'b0, entry_q.state} == match_val_i);

endmodule

// File: rtl/scb_issue_ctrl_pip0.sv
// scb_issue_ctrl_pip0: pipe-0 issue controller and writeback scheduler.
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/req_ready         issue handshake; ready is combinational on req_state
//   req_pip, req_rd_a, req_state  issue payload; writeback lands S+1 cycles after accept
//   CFI_PC_clear                flush all in-flight entries
//   wb_valid, wb_pip, wb_rd_a, wb_ident  single writeback port (zero when idle)
//   hz_fut0, hz_fut1            some entry's countdown equals V_FUT0 / V_FUT1
//   busy_count, full            table occupancy
module scb_issue_ctrl_pip0
    import scb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [W_pip-1:0]   req_pip,
    input  logic [W_PA_rx-1:0] req_rd_a,
    input  logic [W_state-1:0] req_state,
    input  logic               CFI_PC_clear,
    output logic               wb_valid,
    output logic [W_pip-1:0]   wb_pip,
    output logic [W_PA_rx-1:0] wb_rd_a,
    output logic [W_ident-1:0] wb_ident,
    output logic               hz_fut0,
    output logic               hz_fut1,
    output logic [W_cnt-1:0]   busy_count,
    output logic               full
);

    logic [N_CELL-1:0]  inused_vec, wb_vec, fut0_vec, fut1_vec, match_vec, load_vec;
    logic [W_pip-1:0]   pip_arr [N_CELL];
    logic [W_PA_rx-1:0] rd_arr  [N_CELL];
    logic [W_state:0]   match_val;
    logic [W_ident-1:0] alloc_idx;
    logic               accept;
    logic [W_pip+W_PA_rx-1:0] best_key;

    // Widened so that req_state = all-ones maps to a value no entry can hold.
    assign match_val = {1'b0, req_state} + (W_state+1)'(1);

    assign req_ready = !rst && !CFI_PC_clear && !(&inused_vec) && !(|match_vec);
    assign accept    = req_valid && req_ready;
    assign alloc_idx = find_first_free(~inused_vec);

    for (genvar g = 0; g < N_CELL; g++) begin : g_slot
        assign load_vec[g] = accept && (alloc_idx == W_ident'(g));

        scb_slot u_slot (
            .clk         (clk),
            .rst         (rst),
            .clear_i     (CFI_PC_clear),
            .load_i      (load_vec[g]),
            .pip_i       (req_pip),
            .rd_i        (req_rd_a),
            .state_i     (req_state),
            .match_val_i (match_val),
            .inused_o    (inused_vec[g]),
            .pip_o       (pip_arr[g]),
            .rd_o        (rd_arr[g]),
            .is_wb_o     (wb_vec[g]),
            .is_fut0_o   (fut0_vec[g]),
            .is_fut1_o   (fut1_vec[g]),
            .match_o     (match_vec[g])
        );
    end

    // Normally at most one entry is at zero; if several are, the highest
    // {pip,rd} wins and the rest are lost.
    always_comb begin
        wb_valid = 1'b0;
        wb_pip   = '0;
        wb_rd_a  = '0;
        wb_ident = '0;
        best_key = '0;
        for (int i = 0; i < N_CELL; i++) begin
            if (wb_vec[i] && (!wb_valid || ({pip_arr[i], rd_arr[i]} > best_key))) begin
                wb_valid = 1'b1;
                best_key = {pip_arr[i], rd_arr[i]};
                wb_pip   = pip_arr[i];
                wb_rd_a  = rd_arr[i];
                wb_ident = W_ident'(i);
            end
        end
        // Reset drops in-flight work without completing it.
        if (rst) begin
            wb_valid = 1'b0;
            wb_pip   = '0;
            wb_rd_a  = '0;
            wb_ident = '0;
        end
    end

    always_comb begin
        busy_count = '0;
        for (int i = 0; i < N_CELL; i++) begin
            busy_count = busy_count + W_cnt'(inused_vec[i]);
        end
    end

    assign full    = (busy_count == W_cnt'(N_CELL));
    assign hz_fut0 = |fut0_vec;
    assign hz_fut1 = |fut1_vec;

endmodule

// File: tb/tb_scb_issue_ctrl_pip0.sv
module tb_scb_issue_ctrl_pip0;
    import scb_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               req_valid;
    logic               req_ready;
    logic [W_pip-1:0]   req_pip;
    logic [W_PA_rx-1:0] req_rd_a;
    logic [W_state-1:0] req_state;
    logic               CFI_PC_clear;
    logic               wb_valid;
    logic [W_pip-1:0]   wb_pip;
    logic [W_PA_rx-1:0] wb_rd_a;
    logic [W_ident-1:0] wb_ident;
    logic               hz_fut0;
    logic               hz_fut1;
    logic [W_cnt-1:0]   busy_count;
    logic               full;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    scb_issue_ctrl_pip0 dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_pip      (req_pip),
        .req_rd_a     (req_rd_a),
        .req_state    (req_state),
        .CFI_PC_clear (CFI_PC_clear),
        .wb_valid     (wb_valid),
        .wb_pip       (wb_pip),
        .wb_rd_a      (wb_rd_a),
        .wb_ident     (wb_ident),
        .hz_fut0      (hz_fut0),
        .hz_fut1      (hz_fut1),
        .busy_count   (busy_count),
        .full         (full)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W_pip-1:0] pip, input logic [W_PA_rx-1:0] rd,
                         input logic [W_state-1:0] st, input logic clr);
        req_valid    = v;
        req_pip      = pip;
        req_rd_a     = rd;
        req_state    = st;
        CFI_PC_clear = clr;
        #1;
    endtask

    initial begin : main
        int exp_busy;
        logic exp_wb;

        // reset
        rst = 1'b1;
        drive(1'b0, 2'd0, 5'd0, 7'd3, 1'b0);
        step();
        step();
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_wb", 32'(wb_valid), 32'd0);
        rst = 1'b0;
        drive(1'b0, 2'd0, 5'd0, 7'd3, 1'b0);
        chk("post_rst_wb", 32'(wb_valid), 32'd0);
        chk("post_rst_busy", 32'(busy_count), 32'd0);
        chk("post_rst_full", 32'(full), 32'd0);
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        // single issue S=3
        drive(1'b1, 2'd0, 5'd5, 7'd3, 1'b0);
        chk("single_ready", 32'(req_ready), 32'd1);
        step();
        for (int k = 1; k <= 5; k++) begin
            drive(1'b0, 2'd0, 5'd0, 7'd0, 1'b0);
            chk("single_wbv", 32'(wb_valid), 32'(k == 4));
            if (k == 4) begin
                chk("single_rd", 32'(wb_rd_a), 32'd5);
                chk("single_id", 32'(wb_ident), 32'd0);
            end
            chk("single_busy", 32'(busy_count), (k <= 4) ? 32'd1 : 32'd0);
            step();
        end

        // collision
        drive(1'b1, 2'd0, 5'd1, 7'd5, 1'b0);
        chk("coll_first_ready", 32'(req_ready), 32'd1);
        step();
        drive(1'b1, 2'd0, 5'd2, 7'd4, 1'b0);
        chk("coll_s4_ready", 32'(req_ready), 32'd0);
        drive(1'b1, 2'd0, 5'd3, 7'd3, 1'b0);
        chk("coll_s3_ready", 32'(req_ready), 32'd1);
        step();
        for (int k = 2; k <= 7; k++) begin
            drive(1'b0, 2'd0, 5'd0, 7'd0, 1'b0);
            chk("coll_wbv", 32'(wb_valid), 32'(k == 5 || k == 6));
            chk("coll_rd", 32'(wb_rd_a), (k == 5) ? 32'd3 : (k == 6) ? 32'd1 : 32'd0);
            chk("coll_id", 32'(wb_ident), (k == 5) ? 32'd1 : 32'd0);
            chk("coll_busy", 32'(busy_count), (k <= 5) ? 32'd2 : (k == 6) ? 32'd1 : 32'd0);
            step();
        end

        // fill the table with S=20
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2'(i), 5'(i + 8), 7'd20, 1'b0);
            chk("fill_ready", 32'(req_ready), 32'd1);
            chk("fill_busy", 32'(busy_count), 32'(i));
            step();
        end
        for (int c = 8; c <= 34; c++) begin
            if (c <= 21)      drive(1'b1, 2'd0, 5'd0, 7'd20, 1'b0);
            else if (c == 22) drive(1'b1, 2'd0, 5'd31, 7'd10, 1'b0);
            else              drive(1'b0, 2'd0, 5'd0, 7'd0, 1'b0);
            exp_wb = ((c >= 21) && (c <= 28)) || (c == 33);
            chk("full_wbv", 32'(wb_valid), 32'(exp_wb));
            if (c == 33) begin
                chk("full_reissue_id", 32'(wb_ident), 32'd0);
                chk("full_reissue_rd", 32'(wb_rd_a), 32'd31);
            end else if (exp_wb) begin
                chk("full_drain_id", 32'(wb_ident), 32'(c - 21));
                chk("full_drain_rd", 32'(wb_rd_a), 32'(c - 21 + 8));
                chk("full_drain_pip", 32'(wb_pip), 32'((c - 21) % 4));
            end
            if (c <= 22) chk("full_ready", 32'(req_ready), 32'(c == 22));
            chk("full_flag", 32'(full), 32'(c <= 21));
            exp_busy = 0;
            for (int j = 1; j < 8; j++) if (22 + j > c) exp_busy++;
            if (c <= 21)                    exp_busy = 8;
            else if (c >= 23 && c < 34)     exp_busy++;
            chk("full_busy", 32'(busy_count), 32'(exp_busy));
            step();
        end

        // flush with three entries in flight
        drive(1'b1, 2'd0, 5'd1, 7'd5, 1'b0);
        step();
        drive(1'b1, 2'd0, 5'd2, 7'd6, 1'b0);
        step();
        drive(1'b1, 2'd0, 5'd3, 7'd7, 1'b0);
        step();
        drive(1'b1, 2'd0, 5'd4, 7'd10, 1'b1);
        chk("flush_busy_pre", 32'(busy_count), 32'd3);
        chk("flush_ready", 32'(req_ready), 32'd0);
        step();
        drive(1'b0, 2'd0, 5'd0, 7'd0, 1'b0);
        chk("flush_busy_post", 32'(busy_count), 32'd0);
        for (int k = 0; k < 12; k++) begin
            drive(1'b0, 2'd0, 5'd0, 7'd0, 1'b0);
            chk("flush_no_wb", 32'(wb_valid), 32'd0);
            step();
        end

        // hazard flags, S=6
        drive(1'b1, 2'd2, 5'd7, 7'd6, 1'b0);
        chk("hz_ready", 32'(req_ready), 32'd1);
        step();
        for (int k = 1; k <= 8; k++) begin
            if (k == 7) drive(1'b0, 2'd0, 5'd0, 7'd127, 1'b0);
            else        drive(1'b0, 2'd0, 5'd0, 7'd0, 1'b0);
            chk("hz_fut1", 32'(hz_fut1), 32'(k == 3));
            chk("hz_fut0", 32'(hz_fut0), 32'(k == 6));
            chk("hz_wbv", 32'(wb_valid), 32'(k == 7));
            if (k == 6) chk("hz_s0_coll_ready", 32'(req_ready), 32'd0);
            if (k == 7) begin
                chk("hz_wb_pip", 32'(wb_pip), 32'd2);
                chk("allones_ready", 32'(req_ready), 32'd1);
            end
            step();
        end

        // reset mid-operation
        drive(1'b1, 2'd1, 5'd9, 7'd3, 1'b0);
        step();
        rst = 1'b1;
        drive(1'b0, 2'd0, 5'd0, 7'd0, 1'b0);
        chk("midrst_ready", 32'(req_ready), 32'd0);
        step();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 2'd0, 5'd0, 7'd0, 1'b0);
            chk("midrst_no_wb", 32'(wb_valid), 32'd0);
            chk("midrst_busy", 32'(busy_count), 32'd0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
